// File: rtl/multicycle_ctrl.sv
// Multi-cycle Moore controller: FETCH/DECODE/EXEC/MEM/WB with memory handshake, retire counter and trap.
// Define MULT_CTRL_MUL_EN to build the MUL class and the fixed-latency MULT state.
module multicycle_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             branch_eq,
  output logic             branch_ne,
  output logic             jump,
  output logic             link,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src,
  output logic             mult_start,
  output logic             illegal,
  output logic             retire,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
    S_WB = 3'd4, S_MULT = 3'd5, S_TRAP = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_RALU = 4'd0, C_IALU = 4'd1, C_LW = 4'd2, C_SW = 4'd3, C_J = 4'd4,
    C_JAL = 4'd5, C_BEQ = 4'd6, C_BNE = 4'd7, C_MUL = 4'd8, C_ILL = 4'd9
  } class_t;

  state_t           r_state;
  state_t           w_next;
  logic [5:0]       r_op;
  logic [5:0]       r_funct;
  logic [CNT_W-1:0] r_cnt;
  class_t           w_cls;

  function automatic class_t decode(input logic [5:0] op, input logic [5:0] fn);
    class_t c;
    c = C_ILL;
    case (op)
      6'h00: begin
        if ((fn >= 6'h20 && fn <= 6'h26) || (fn >= 6'h28 && fn <= 6'h2D) ||
            fn == 6'h04 || fn == 6'h06 || fn == 6'h07) c = C_RALU;
        else c = C_ILL;
      end
`ifdef MULT_CTRL_MUL_EN
      6'h01: begin
        if (fn == 6'h0E || fn == 6'h16) c = C_MUL;
        else c = C_ILL;
      end
`endif
      6'h23: c = C_LW;
      6'h2B: c = C_SW;
      6'h02, 6'h12: c = C_J;
      6'h03, 6'h13: c = C_JAL;
      6'h04: c = C_BEQ;
      6'h05: c = C_BNE;
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h14, 6'h16, 6'h17,
      6'h18, 6'h19, 6'h1A, 6'h1B, 6'h1C, 6'h1D: c = C_IALU;
      default: c = C_ILL;
    endcase
    return c;
  endfunction

  assign w_cls       = decode(r_op, r_funct);
  assign state       = r_state;
  assign retired_cnt = r_cnt;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // instruction register: only opcode and funct drive decoding
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= 6'd0;
      r_funct <= 6'd0;
    end else if (ir_write) begin
      r_op    <= instr[31:26];
      r_funct <= instr[5:0];
    end
  end

  // retired-instruction counter, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_cnt <= '0;
    else if (retire) r_cnt <= r_cnt + CNT_W'(1);
  end

`ifdef MULT_CTRL_MUL_EN
  logic [7:0] r_mcnt;

  // multiplier latency counter, zeroed on the way into MULT
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_mcnt <= 8'd0;
    else if (r_state == S_EXEC) r_mcnt <= 8'd0;
    else if (r_state == S_MULT) r_mcnt <= r_mcnt + 8'd1;
  end
`endif

  // next state and Moore strobes; everything held low while rst is high
  always_comb begin
    w_next     = r_state;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch_eq  = 1'b0;
    branch_ne  = 1'b0;
    jump       = 1'b0;
    link       = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    mult_start = 1'b0;
    illegal    = 1'b0;
    retire     = 1'b0;
    if (rst) begin
      w_next = S_FETCH;
    end else begin
      case (r_state)
        S_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            w_next   = S_DECODE;
          end else begin
            w_next = S_FETCH;
          end
        end
        S_DECODE: begin
          if (w_cls == C_ILL) w_next = S_TRAP;
          else                w_next = S_EXEC;
        end
        S_EXEC: begin
          case (w_cls)
            C_RALU: begin reg_dst = 1'b1; w_next = S_WB; end
            C_IALU: begin alu_src = 1'b1; w_next = S_WB; end
            C_LW, C_SW: begin alu_src = 1'b1; w_next = S_MEM; end
            C_J: begin jump = 1'b1; pc_write = 1'b1; retire = 1'b1; w_next = S_FETCH; end
            C_JAL: begin jump = 1'b1; pc_write = 1'b1; w_next = S_WB; end
            C_BEQ: begin branch_eq = 1'b1; alu_src = 1'b1; retire = 1'b1; w_next = S_FETCH; end
            C_BNE: begin branch_ne = 1'b1; alu_src = 1'b1; retire = 1'b1; w_next = S_FETCH; end
`ifdef MULT_CTRL_MUL_EN
            C_MUL: begin mult_start = 1'b1; reg_dst = 1'b1; w_next = S_MULT; end
`endif
            default: w_next = S_TRAP;
          endcase
        end
        S_MEM: begin
          if (w_cls == C_LW) mem_read = 1'b1;
          else               mem_write = 1'b1;
          if (!mem_ready)          w_next = S_MEM;
          else if (w_cls == C_LW)  w_next = S_WB;
          else begin
            retire = 1'b1;
            w_next = S_FETCH;
          end
        end
`ifdef MULT_CTRL_MUL_EN
        S_MULT: begin
          if (r_mcnt == 8'(MULT_CYCLES - 1)) w_next = S_WB;
          else                               w_next = S_MULT;
        end
`endif
        S_WB: begin
          reg_write  = 1'b1;
          retire     = 1'b1;
          mem_to_reg = (w_cls == C_LW);
          reg_dst    = (w_cls == C_RALU) || (w_cls == C_MUL);
          link       = (w_cls == C_JAL);
          w_next     = S_FETCH;
        end
        S_TRAP: begin
          illegal = 1'b1;
          w_next  = S_TRAP;
        end
        default: w_next = S_TRAP;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed + random bench for multicycle_ctrl: per-instruction expected traces built from the class rules.
module tb_multicycle_ctrl;
  localparam int TB_MC = 4;
  localparam int TB_CW = 4;

  localparam logic [14:0] MRD = 15'h4000, MWR = 15'h2000, IRW = 15'h1000, PCW = 15'h0800;
  localparam logic [14:0] BEQ = 15'h0400, BNE = 15'h0200, JMP = 15'h0100, LNK = 15'h0080;
  localparam logic [14:0] M2R = 15'h0040, RDST = 15'h0020, RWR = 15'h0010, ASRC = 15'h0008;
  localparam logic [14:0] MST = 15'h0004, ILL = 15'h0002, RET = 15'h0001;

  localparam int K_RALU = 0, K_IALU = 1, K_LW = 2, K_SW = 3, K_J = 4;
  localparam int K_JAL = 5, K_BEQ = 6, K_BNE = 7, K_MUL = 8, K_ILL = 9;

  localparam logic [5:0] OPS [0:19] = '{6'h23, 6'h2B, 6'h02, 6'h12, 6'h03, 6'h13, 6'h04, 6'h05,
    6'h08, 6'h0E, 6'h0F, 6'h14, 6'h15, 6'h16, 6'h17, 6'h18, 6'h1D, 6'h1E, 6'h11, 6'h3F};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_ready = 1'b0;
  logic [31:0] instr = 32'd0;
  logic mem_read, mem_write, ir_write, pc_write, branch_eq, branch_ne, jump, link;
  logic mem_to_reg, reg_dst, reg_write, alu_src, mult_start, illegal, retire;
  logic [TB_CW-1:0] retired_cnt;
  logic [2:0] state;
  logic [14:0] obs;

  typedef struct {
    logic       rdy;
    logic [2:0] st;
    logic [14:0] vec;
  } step_t;

  step_t trace[$];
  int errors = 0;
  int checks = 0;
  int model_cnt = 0;

  multicycle_ctrl #(.MULT_CYCLES(TB_MC), .CNT_W(TB_CW)) dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
    .branch_eq(branch_eq), .branch_ne(branch_ne), .jump(jump), .link(link),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write), .alu_src(alu_src),
    .mult_start(mult_start), .illegal(illegal), .retire(retire),
    .retired_cnt(retired_cnt), .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {mem_read, mem_write, ir_write, pc_write, branch_eq, branch_ne, jump, link,
                mem_to_reg, reg_dst, reg_write, alu_src, mult_start, illegal, retire};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int classify(input logic [31:0] w);
    logic [5:0] op;
    logic [5:0] fn;
    op = w[31:26];
    fn = w[5:0];
    if (op == 6'h00)
      return (fn inside {[6'h20:6'h26], [6'h28:6'h2D], 6'h04, 6'h06, 6'h07}) ? K_RALU : K_ILL;
    if (op == 6'h01) begin
`ifdef MULT_CTRL_MUL_EN
      return (fn == 6'h0E || fn == 6'h16) ? K_MUL : K_ILL;
`else
      return K_ILL;
`endif
    end
    if (op == 6'h23) return K_LW;
    if (op == 6'h2B) return K_SW;
    if (op inside {6'h02, 6'h12}) return K_J;
    if (op inside {6'h03, 6'h13}) return K_JAL;
    if (op == 6'h04) return K_BEQ;
    if (op == 6'h05) return K_BNE;
    if (op inside {[6'h08:6'h0E], 6'h14, 6'h16, 6'h17, [6'h18:6'h1D]}) return K_IALU;
    return K_ILL;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input logic r, input logic [2:0] s, input logic [14:0] v);
    step_t e;
    e.rdy = r;
    e.st  = s;
    e.vec = v;
    trace.push_back(e);
  endfunction

  // Expected cycle-by-cycle trace of one instruction: fw fetch waits, mw data waits.
  function automatic void build(input logic [31:0] w, input int fw, input int mw);
    int k;
    k = classify(w);
    trace.delete();
    for (int i = 0; i < fw; i++) push(1'b0, 3'd0, MRD);
    push(1'b1, 3'd0, MRD | IRW | PCW);
    push(rnd(), 3'd1, 15'h0);
    case (k)
      K_RALU: begin push(rnd(), 3'd2, RDST); push(rnd(), 3'd4, RWR | RDST | RET); end
      K_IALU: begin push(rnd(), 3'd2, ASRC); push(rnd(), 3'd4, RWR | RET); end
      K_LW: begin
        push(rnd(), 3'd2, ASRC);
        for (int i = 0; i < mw; i++) push(1'b0, 3'd3, MRD);
        push(1'b1, 3'd3, MRD);
        push(rnd(), 3'd4, RWR | M2R | RET);
      end
      K_SW: begin
        push(rnd(), 3'd2, ASRC);
        for (int i = 0; i < mw; i++) push(1'b0, 3'd3, MWR);
        push(1'b1, 3'd3, MWR | RET);
      end
      K_J:   push(rnd(), 3'd2, JMP | PCW | RET);
      K_JAL: begin push(rnd(), 3'd2, JMP | PCW); push(rnd(), 3'd4, RWR | LNK | RET); end
      K_BEQ: push(rnd(), 3'd2, BEQ | ASRC | RET);
      K_BNE: push(rnd(), 3'd2, BNE | ASRC | RET);
      K_MUL: begin
        push(rnd(), 3'd2, MST | RDST);
        for (int i = 0; i < TB_MC; i++) push(rnd(), 3'd5, 15'h0);
        push(rnd(), 3'd4, RWR | RDST | RET);
      end
      default: push(rnd(), 3'd7, ILL);
    endcase
  endfunction

  task automatic check(input logic [2:0] es, input logic [14:0] ev, input string tag);
    logic [TB_CW-1:0] ec;
    ec = model_cnt[TB_CW-1:0];
    checks++;
    assert (state === es) else begin
      errors++;
      $error("FAIL %s state: got %0d expected %0d", tag, state, es);
    end
    checks++;
    assert (obs === ev) else begin
      errors++;
      $error("FAIL %s outputs: got %h expected %h", tag, obs, ev);
    end
    checks++;
    assert (retired_cnt === ec) else begin
      errors++;
      $error("FAIL %s retired_cnt: got %0d expected %0d", tag, retired_cnt, ec);
    end
  endtask

  task automatic play(input logic [31:0] w, input int limit, input string tag);
    for (int i = 0; i < trace.size() && i < limit; i++) begin
      @(negedge clk);
      rst = 1'b0;
      mem_ready = trace[i].rdy;
      instr = (trace[i].st == 3'd0 && trace[i].rdy) ? w : $urandom;
      #1;
      check(trace[i].st, trace[i].vec, tag);
      if ((trace[i].vec & RET) != 15'h0) model_cnt = (model_cnt + 1) % (1 << TB_CW);
    end
  endtask

  // Async reset asserted between clock edges, then held n further cycles.
  task automatic do_reset(input int n);
    @(negedge clk);
    #2;
    rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    model_cnt = 0;
    check(3'd0, 15'h0, "async_rst");
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mem_ready = rnd();
      instr = $urandom;
      #1;
      check(3'd0, 15'h0, "rst_hold");
    end
  endtask

  task automatic run(input logic [31:0] w, input int fw, input int mw, input int hold, input string tag);
    build(w, fw, mw);
    play(w, 1000, tag);
    if (classify(w) == K_ILL) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        mem_ready = rnd();
        instr = $urandom;
        #1;
        check(3'd7, ILL, "trap_hold");
      end
      do_reset(1);
    end
  endtask

  initial begin
    logic [31:0] w;
    int r;
    do_reset(3);
    run(32'h00430820, 0, 0, 2, "add");
    run(32'h8C410004, 0, 2, 2, "lw_wait2");
    run(32'hAC410008, 1, 1, 2, "sw");
    run(32'h08000010, 0, 0, 2, "j");
    run(32'h0C000010, 2, 0, 2, "jal");
    run(32'h10200004, 0, 0, 2, "beqz");
    run(32'h14200004, 0, 0, 2, "bnez");
    run(32'h20410005, 0, 0, 2, "addi");
    run(32'h0443080E, 0, 0, 20, "mul");
    run(32'hFC000000, 0, 0, 20, "op3f");
    // aborted LW: reset while waiting in MEM must not retire
    build(32'h8C410004, 0, 3);
    play(32'h8C410004, 5, "lw_abort");
    do_reset(1);
    for (int i = 0; i < 20; i++) run(32'h08000000 | (32'($urandom) & 32'h03FFFFFF), 0, 0, 2, "j_wrap");
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) w = $urandom;
      else if (r == 1) w = {6'h00, 20'($urandom), 6'($urandom)};
      else if (r == 2) w = {6'h01, 20'($urandom), (rnd() ? 6'h0E : 6'h16)};
      else if (r == 3) w = {6'h00, 20'($urandom), 6'h20 + 6'($urandom_range(0, 13))};
      else w = {OPS[$urandom_range(0, 19)], 26'($urandom)};
      run(w, $urandom_range(0, 3), $urandom_range(0, 3), 3, "random");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

- Multi-cycle main controller for the DLX-style core: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback phases.
- Supports a variable-latency memory handshake and a fixed-latency multiplier, counts retired instructions, and traps on unrecognised encodings.
- Sits between instruction/data memory and the datapath, replacing the single-cycle decoder in the multi-cycle core build.

## Interface
- `MULT_CYCLES`, default 4: cycles spent in MULT state; legal range 1..255.
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `instr` in 32: memory read data; captured into the internal IR on `ir_write`.
- `mem_ready` in 1: memory access completes this cycle.
- `mem_read`, `mem_write` out 1: memory access strobes.
- `ir_write`, `pc_write` out 1: IR and PC update enables.
- `branch_eq`, `branch_ne`, `jump`, `link` out 1: PC source and link control.
- `mem_to_reg`, `reg_dst`, `reg_write`, `alu_src` out 1: datapath selects and enables.
- `mult_start` out 1: one-cycle multiplier start pulse.
- `illegal` out 1: sticky trap flag.
- `retire` out 1: instruction-completion pulse.
- `retired_cnt` out CNT_W: count of retired instructions.
- `state` out 3: current state, for debug.

## Operation
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MULT=5, TRAP=7.
- Decode classes, from latched IR opcode `[31:26]` and funct `[5:0]`:
  - R-ALU: op 0x00 with funct in 0x20–0x26, 0x28–0x2D, 0x04, 0x06 or 0x07.
  - MUL: op 0x01 with funct 0x0E or 0x16.
  - LW: 0x23. SW: 0x2B.
  - J: 0x02, 0x12. JAL: 0x03, 0x13.
  - BEQZ: 0x04. BNEZ: 0x05.
  - I-ALU: 0x08–0x0E, 0x14, 0x16, 0x17, 0x18–0x1D.
  - Anything else is ILLEGAL.
- FETCH: `mem_read`=1. Stay in FETCH while `mem_ready`=0. When `mem_ready`=1, assert `ir_write`=1 and `pc_write`=1 (PC+4), then go to DECODE.
- DECODE: one cycle with no strobes. ILLEGAL goes to TRAP; all other classes go to EXEC.
- EXEC:
  - R-ALU: `reg_dst`=1, then WB.
  - I-ALU: `alu_src`=1, then WB.
  - LW/SW: `alu_src`=1, then MEM.
  - J: `jump`=1, `pc_write`=1, retire, then FETCH.
  - JAL: `jump`=1, `pc_write`=1, then WB.
  - BEQZ: `branch_eq`=1, `alu_src`=1, retire, then FETCH. BNEZ is identical with `branch_ne`=1. The datapath gates the PC update with the zero flag.
  - MUL: `mult_start`=1, `reg_dst`=1, then MULT.
- MEM:
  - LW: `mem_read`=1; SW: `mem_write`=1. Hold in MEM until `mem_ready`=1.
  - On that cycle, LW goes to WB; SW retires and goes to FETCH.
- MULT: an internal 8-bit counter loads 0 on entry. Exit to WB in the cycle the counter equals MULT_CYCLES−1.
- WB: `reg_write`=1, retire, then FETCH.
  - `mem_to_reg`=1 for LW. `reg_dst`=1 for R-ALU and MUL. `link`=1 for JAL (writes r31).
- TRAP: `illegal`=1, all other outputs 0. No exit except reset.
- Retire: `retire` pulses for one cycle and `retired_cnt` increments by 1 on the following edge. The counter wraps from 2^CNT_W−1 to 0.
- Only the listed strobes are 1 in each state; all others are 0.

## Timing
- Reset (async): `state`=FETCH, IR=0, `retired_cnt`=0, MULT counter=0.
- While `rst`=1, every output is 0, including `mem_read`. `mem_read`=1 from the first cycle after deassertion.
- Reset mid-instruction aborts it immediately with no retire pulse. Reset in TRAP clears `illegal`.
- Outputs are combinational from `state` and the latched IR (Moore); `instr` never feeds outputs directly.
- Latencies with zero memory wait:
  - ALU: 4 cycles. J and branch: 3. JAL: 4. LW: 5. SW: 4. MUL: 4+MULT_CYCLES.
  - Each memory wait cycle adds one.
- `mem_ready` is sampled only in FETCH and MEM; it is ignored elsewhere.

## Configuration
- `MULT_CTRL_MUL_EN`:
  - Defined: MUL class and MULT state as above.
  - Undefined: op 0x01 decodes as ILLEGAL; `mult_start` ties to 0; the MULT state and counter are not built.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with `mem_ready`=1 → all outputs 0. First cycle after release: `state`=0, `mem_read`=1.
- ADD (0x00430820) with `mem_ready`=1 → states 0,1,2,4. `reg_write`=1 at cycle 4. `retired_cnt`=1.
- LW (0x8C410004), data `mem_ready` delayed 2 cycles → MEM held 3 cycles, WB with `mem_to_reg`=1, 7 cycles total.
- MUL (op 0x01, funct 0x0E), MULT_CYCLES=4 → `mult_start` pulses once, 4 cycles in MULT, then WB. Without the macro: TRAP, `illegal`=1.
- Opcode 0x3F → TRAP. `illegal` stays 1 for 20 cycles and `retired_cnt` is frozen. Async `rst` clears both.
- CNT_W=4, 16 back-to-back J instructions → `retired_cnt` wraps 15→0.
